// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets several byte sources share
// one UART transmitter. A requester may hold the grant across bytes by
// asserting req_lock; an idle lock is revoked after LOCK_TIMEOUT cycles.
//
// Ports:
//   wb_clk_i      clock, rising edge
//   wb_rst_i      synchronous active-high reset
//   req_valid     per-requester byte pending
//   req_data      per-requester byte, requester i at [8i+7:8i]
//   req_lock      per-requester request to keep the grant after this byte
//   req_ready     per-requester byte accepted this cycle (combinational)
//   tx_valid      byte presented to the UART TX engine
//   tx_data       byte to the UART TX engine
//   tx_ready      UART TX engine accepts tx_data this cycle
//   grant_id      current / last owner index
//   grant_active  high while a requester owns the transmitter (SEND, LOCKED)
//   lock_timeout  one-cycle pulse when an idle lock is revoked
module uart_tx_arbiter #(
  parameter int unsigned REQUESTERS   = 4,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [REQUESTERS-1:0]         req_valid,
  input  logic [8*REQUESTERS-1:0]       req_data,
  input  logic [REQUESTERS-1:0]         req_lock,
  output logic [REQUESTERS-1:0]         req_ready,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  input  logic                          tx_ready,
  output logic [$clog2(REQUESTERS)-1:0] grant_id,
  output logic                          grant_active,
  output logic                          lock_timeout
);

  localparam int unsigned ID_W  = $clog2(REQUESTERS);
  localparam int unsigned IDX_W = ID_W + 1;
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [7:0]        tx_data_next;
  logic              tx_valid_next;
  logic              grant_active_next;
  logic              lock_timeout_next;
  logic              lock_bit, lock_bit_next;
  logic [ID_W-1:0]   grant_id_next;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_next;
  logic [CNT_W-1:0]  idle_cnt, idle_cnt_next;

  logic              any_valid;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   sel;
  logic              accept;

  // Round-robin search starting at rr_ptr, wrapping past REQUESTERS-1.
  always_comb begin
    logic [IDX_W-1:0] cand;
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      cand = {1'b0, rr_ptr} + IDX_W'(i);
      if (cand >= IDX_W'(REQUESTERS)) begin
        cand = cand - IDX_W'(REQUESTERS);
      end
      if (!any_valid && req_valid[cand[ID_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[ID_W-1:0];
      end
    end
  end

  // Next-state, capture and handshake logic.
  always_comb begin
    state_next        = state;
    tx_data_next      = tx_data;
    lock_bit_next     = lock_bit;
    grant_id_next     = grant_id;
    rr_ptr_next       = rr_ptr;
    idle_cnt_next     = idle_cnt;
    lock_timeout_next = 1'b0;
    req_ready         = '0;
    accept            = 1'b0;
    sel               = winner;

    case (state)
      IDLE: begin
        if (any_valid) begin
          accept = 1'b1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          rr_ptr_next   = (grant_id == ID_W'(REQUESTERS - 1)) ? '0
                                                              : grant_id + ID_W'(1);
          idle_cnt_next = '0;
          state_next    = lock_bit ? LOCKED : IDLE;
        end
      end
      LOCKED: begin
        sel = grant_id;
        if (req_valid[grant_id]) begin
          accept = 1'b1;
        end else if (!req_lock[grant_id]) begin
          // Owner gave the lock up voluntarily: no timeout pulse.
          state_next = IDLE;
        end else if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_next        = IDLE;
          idle_cnt_next     = '0;
          lock_timeout_next = 1'b1;
        end else begin
          idle_cnt_next = idle_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept) begin
      req_ready[sel] = 1'b1;
      tx_data_next   = req_data[{sel, 3'b000} +: 8];
      lock_bit_next  = req_lock[sel];
      grant_id_next  = sel;
      idle_cnt_next  = '0;
      state_next     = SEND;
    end

    // No acceptance is visible while reset is asserted.
    if (wb_rst_i) begin
      req_ready = '0;
    end

    tx_valid_next     = (state_next == SEND);
    grant_active_next = (state_next != IDLE);
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      lock_timeout <= 1'b0;
      rr_ptr       <= '0;
      lock_bit     <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      state        <= state_next;
      tx_valid     <= tx_valid_next;
      tx_data      <= tx_data_next;
      grant_id     <= grant_id_next;
      grant_active <= grant_active_next;
      lock_timeout <= lock_timeout_next;
      rr_ptr       <= rr_ptr_next;
      lock_bit     <= lock_bit_next;
      idle_cnt     <= idle_cnt_next;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter REQUESTERS, default 4, number of byte sources sharing one UART transmitter (range 2..8).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, cycles a locked owner may idle before its lock is revoked.
REQ-003 SHALL have port wb_clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  REQUESTERS  requester i has a byte pending.
REQ-006 SHALL have port req_data  input  8*REQUESTERS  byte of requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_lock  input  REQUESTERS  requester i wants to keep the grant after this byte.
REQ-008 SHALL have port req_ready  output  REQUESTERS  byte of requester i accepted this cycle (combinational).
REQ-009 SHALL have port tx_valid  output  1  byte presented to UART TX engine.
REQ-010 SHALL have port tx_data  output  8  byte to UART TX engine.
REQ-011 SHALL have port tx_ready  input  1  UART TX engine accepts tx_data this cycle.
REQ-012 SHALL have port grant_id  output  $clog2(REQUESTERS)  current/last owner index.
REQ-013 SHALL have port grant_active  output  1  high in SEND and LOCKED.
REQ-014 SHALL have port lock_timeout  output  1  one-cycle pulse when a lock is revoked by timeout.

Function
REQ-015 SHALL implement states IDLE, SEND, LOCKED.
REQ-016 IDLE: winner = first i with req_valid[i] searching from rr_ptr upward with wrap-around; req_ready[winner]=1 only, same cycle.
REQ-017 On IDLE accept: tx_data<=req_data[winner], lock_bit<=req_lock[winner], grant_id<=winner, state->SEND next cycle.
REQ-018 IDLE with no req_valid: all req_ready low, state stays IDLE.
REQ-019 SEND: tx_valid=1, tx_data stable until tx_valid&&tx_ready; all req_ready low.
REQ-020 On SEND handshake: rr_ptr<=(grant_id+1) mod REQUESTERS; state->LOCKED if lock_bit else IDLE; tx_valid low next cycle.
REQ-021 Latency: byte accepted in cycle N appears on tx_valid in cycle N+1; minimum 2 cycles per byte per requester.
REQ-022 LOCKED: only owner considered; req_ready[owner]=req_valid[owner]; other requesters' req_valid ignored.
REQ-023 LOCKED accept: same capture as REQ-017, state->SEND, idle counter cleared.
REQ-024 LOCKED, owner req_valid=0 and req_lock=0: state->IDLE next cycle, no pulse.
REQ-025 LOCKED, owner req_valid=1 and req_lock=0 same cycle: byte accepted, new lock_bit=0, release after that byte.
REQ-026 LOCKED idle counter increments each cycle without owner accept; at count LOCK_TIMEOUT-1 state->IDLE and lock_timeout pulses one cycle.
REQ-027 Idle counter SHALL be cleared on entering LOCKED and on every accept; width $clog2(LOCK_TIMEOUT)+1, no wrap.
REQ-028 tx_ready while tx_valid low SHALL be ignored.
REQ-029 grant_id SHALL hold its value in IDLE (last owner).

Reset
REQ-030 On wb_clk_i edge with wb_rst_i=1: state=IDLE, tx_valid=0, tx_data=0, grant_id=0, grant_active=0, lock_timeout=0, rr_ptr=0, lock_bit=0, idle counter=0.
REQ-031 Reset mid-SEND SHALL drop the held byte (not retransmitted); req_ready all low while wb_rst_i=1.

Verification
REQ-032 Single: req_valid=0001, data[0]=0x55, tx_ready=1 -> req_ready=0001 cycle N, tx_valid/tx_data=0x55 cycle N+1, IDLE N+2.
REQ-033 Round-robin: all four valid continuously, no lock, tx_ready=1 -> tx order 0,1,2,3,0; grant_id matches.
REQ-034 Lock: req 2 sends 3 bytes with req_lock=1 then lock=0 on last while req 0 valid -> bytes of 2 contiguous, req 0 served next.
REQ-035 Backpressure: tx_ready=0 for 5 cycles in SEND -> tx_data stable, req_ready all low, then single handshake.
REQ-036 Timeout: LOCK_TIMEOUT=8, owner 1 locked, no further valid -> lock_timeout pulse 8 cycles after entering LOCKED, then req 3 granted.
REQ-037 Reset mid-SEND: wb_rst_i=1 one cycle with tx_valid=1 -> next cycle tx_valid=0, grant_id=0, rr_ptr=0.
